// File: rtl/limber_gnrl_rr_arb_if.sv
// Valid/ready bundle for the round-robin arbiter: NREQ requester channels in, one registered beat out.
// The master modport is the arbiter side; the slave modport is the requesters plus downstream.
interface limber_gnrl_rr_arb_if #(
    parameter int NREQ = 4,
    parameter int DW   = 32
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*DW-1:0] req_data;
    logic               out_valid;
    logic               out_ready;
    logic [DW-1:0]      out_data;
    logic [IDW-1:0]     out_id;

    modport master (
        input  req_valid, req_data, out_ready,
        output req_ready, out_valid, out_data, out_id
    );

    modport slave (
        output req_valid, req_data, out_ready,
        input  req_ready, out_valid, out_data, out_id
    );
endinterface

// File: rtl/limber_gnrl_rr_arb.sv
// Round-robin arbiter feeding a single registered valid/ready stage.
// The winner of each capture becomes lowest priority for the next one.
module limber_gnrl_rr_arb #(
    parameter int NREQ = 4,
    parameter int DW   = 32
) (
    input logic                clk,
    input logic                rst,
    limber_gnrl_rr_arb_if.master bus
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [IDW-1:0]     ptr;
    logic [IDW-1:0]     win;
    logic [IDW-1:0]     ptr_nxt;
    logic               found;
    logic               load_en;
    logic [DW-1:0]      win_data;
    logic [2*NREQ-1:0]  valid_rot;
    logic [NREQ-1:0]    grant;

    logic               out_valid_q;
    logic [DW-1:0]      out_data_q;
    logic [IDW-1:0]     out_id_q;

    // The register can take a new beat when empty or being drained; nothing is accepted in reset.
    assign load_en = (!out_valid_q || bus.out_ready) && !rst;

    // Rotate the valid vector so position 0 is the current priority pointer.
    always_comb begin
        int sum;
        win       = '0;
        found     = 1'b0;
        sum       = 0;
        valid_rot = {bus.req_valid, bus.req_valid} >> ptr;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && valid_rot[k]) begin
                found = 1'b1;
                sum   = int'(ptr) + k;
                if (sum >= NREQ) begin
                    sum = sum - NREQ;
                end
                win = IDW'(sum);
            end
        end
    end

    always_comb begin
        grant    = '0;
        win_data = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (win == IDW'(k)) begin
                grant[k] = found;
                win_data = bus.req_data[k*DW +: DW];
            end
        end
    end

    assign ptr_nxt       = (win == IDW'(NREQ - 1)) ? '0 : win + 1'b1;
    assign bus.req_ready = load_en ? grant : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_id_q    <= '0;
            ptr         <= '0;
        end else if (load_en) begin
            if (found) begin
                out_valid_q <= 1'b1;
                out_data_q  <= win_data;
                out_id_q    <= win;
                ptr         <= ptr_nxt;
            end else begin
                // Drain with nothing to refill: data/id keep their last values.
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_id    = out_id_q;
endmodule

// File: tb/tb_limber_gnrl_rr_arb.sv
// Directed bench for limber_gnrl_rr_arb with NREQ=4, DW=32; expected values are hand-computed.
module tb_limber_gnrl_rr_arb;
    logic        clk;
    logic        rst;
    logic [31:0] dat [4];
    int          total;
    int          bad;
    int          cnt [4];
    int          exp_id [6];

    limber_gnrl_rr_arb_if #(.NREQ(4), .DW(32)) bus ();

    limber_gnrl_rr_arb #(.NREQ(4), .DW(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    assign bus.req_data = {dat[3], dat[2], dat[1], dat[0]};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        exp_id = '{0, 1, 2, 3, 0, 1};
        for (int i = 0; i < 4; i++) begin
            cnt[i] = 0;
            dat[i] = 32'hDEAD_0000 + i;
        end

        // reset with everything requesting
        rst           = 1'b1;
        bus.req_valid = 4'hF;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            #1;
            chk("rst_ready", bus.req_ready, 4'b0000);
            tick();
            chk("rst_valid", bus.out_valid, 1'b0);
            chk("rst_data",  bus.out_data, 32'h0);
            chk("rst_id",    bus.out_id, 2'd0);
            chk("rst_ready_post", bus.req_ready, 4'b0000);
        end
        chk("rst_ptr", dut.ptr, 2'd0);

        // single streamer on requester 0
        rst           = 1'b0;
        bus.req_valid = 4'b0001;
        for (int k = 1; k <= 3; k++) begin
            dat[0] = k;
            #1;
            chk("s_ready", bus.req_ready, 4'b0001);
            tick();
            chk("s_valid", bus.out_valid, 1'b1);
            chk("s_data",  bus.out_data, k);
            chk("s_id",    bus.out_id, 2'd0);
        end
        bus.req_valid = 4'b0000;
        #1;
        chk("drain_ready", bus.req_ready, 4'b0000);
        tick();
        chk("drain_valid", bus.out_valid, 1'b0);
        chk("drain_hold",  bus.out_data, 32'd3);
        chk("drain_ptr",   dut.ptr, 2'd1);

        // all requesters valid from ptr=0
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.req_valid = 4'hF;
        for (int n = 0; n < 6; n++) begin
            for (int i = 0; i < 4; i++) dat[i] = 16*i + cnt[i];
            #1;
            chk("rr_ready", bus.req_ready, 4'b0001 << exp_id[n]);
            tick();
            chk("rr_id",   bus.out_id, exp_id[n]);
            chk("rr_data", bus.out_data, 16*exp_id[n] + cnt[exp_id[n]]);
            cnt[exp_id[n]]++;
        end
        chk("rr_ptr", dut.ptr, 2'd2);

        // backpressure on a held A5 beat
        bus.req_valid = 4'b0100;
        dat[2] = 32'hA5;
        #1;
        chk("bp_load_ready", bus.req_ready, 4'b0100);
        tick();
        chk("bp_load_data", bus.out_data, 32'hA5);
        bus.out_ready = 1'b0;
        bus.req_valid = 4'hF;
        dat[3] = 32'h30;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("bp_ready", bus.req_ready, 4'b0000);
            tick();
            chk("bp_valid", bus.out_valid, 1'b1);
            chk("bp_data",  bus.out_data, 32'hA5);
            chk("bp_id",    bus.out_id, 2'd2);
        end
        bus.out_ready = 1'b1;
        #1;
        chk("bp_rel_ready", bus.req_ready, 4'b1000);
        tick();
        chk("bp_rel_id",   bus.out_id, 2'd3);
        chk("bp_rel_data", bus.out_data, 32'h30);
        chk("bp_rel_ptr",  dut.ptr, 2'd0);

        // wrap from ptr=3 with requesters 0 and 3
        bus.req_valid = 4'b0100;
        dat[2] = 32'h22;
        tick();
        chk("wr_pre_id",  bus.out_id, 2'd2);
        chk("wr_pre_ptr", dut.ptr, 2'd3);
        bus.req_valid = 4'b1001;
        dat[3] = 32'h33;
        dat[0] = 32'h44;
        #1;
        chk("wr_ready3", bus.req_ready, 4'b1000);
        tick();
        chk("wr_id3",   bus.out_id, 2'd3);
        chk("wr_data3", bus.out_data, 32'h33);
        chk("wr_ptr0",  dut.ptr, 2'd0);
        bus.req_valid = 4'b0001;
        #1;
        chk("wr_ready0", bus.req_ready, 4'b0001);
        tick();
        chk("wr_id0",   bus.out_id, 2'd0);
        chk("wr_data0", bus.out_data, 32'h44);
        chk("wr_ptr1",  dut.ptr, 2'd1);

        // reset while a beat is stalled
        bus.out_ready = 1'b0;
        bus.req_valid = 4'hF;
        tick();
        chk("mr_hold_valid", bus.out_valid, 1'b1);
        rst = 1'b1;
        #1;
        chk("mr_ready", bus.req_ready, 4'b0000);
        tick();
        chk("mr_valid", bus.out_valid, 1'b0);
        chk("mr_data",  bus.out_data, 32'h0);
        chk("mr_ptr",   dut.ptr, 2'd0);
        rst           = 1'b0;
        bus.req_valid = 4'b1010;
        bus.out_ready = 1'b1;
        dat[1] = 32'h55;
        #1;
        chk("mr_first_ready", bus.req_ready, 4'b0010);
        tick();
        chk("mr_first_id",   bus.out_id, 2'd1);
        chk("mr_first_data", bus.out_data, 32'h55);
        bus.req_valid = 4'b0000;
        tick();
        chk("end_valid", bus.out_valid, 1'b0);
        chk("end_hold",  bus.out_data, 32'h55);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
